// File: rtl/cyq_coin_payout_pkg.sv
// cyq_coin_payout_pkg: shared state encodings, coin units and timeout default for the coin payout block.
package cyq_coin_payout_pkg;
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    REL  = 3'd2,
    DONE = 3'd3,
    ERR  = 3'd4
  } state_e;
  localparam logic [2:0] COIN_1  = 3'd2;
  localparam logic [2:0] COIN_05 = 3'd1;
  localparam int TIMEOUT_DEF = 16;
endpackage

// File: rtl/cyq_timeout_cnt.sv
// cyq_timeout_cnt: counts request cycles and flags the last permitted one.
module cyq_timeout_cnt
  import cyq_coin_payout_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);
  logic [4:0] cnt_q;
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) cnt_q <= '0;
    else if (enable_i && !expired_o) cnt_q <= cnt_q + 5'd1;
  end
  assign expired_o = cnt_q == 5'(TIMEOUT - 1);
endmodule

// File: rtl/cyq_coin_payout.sv
// cyq_coin_payout: pays change as 1-yuan then 0.5-yuan hopper requests with ack handshake and timeout.
module cyq_coin_payout
  import cyq_coin_payout_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic [2:0] amount_i,
  input  logic       hop_ack_i,
  output logic       hop_1_o,
  output logic       hop_05_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o
);
  state_e     state_q, state_d;
  logic [2:0] rem_q, rem_d;
  logic       err_q, err_d;
  logic       expired;
  cyq_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clear_i   (state_q != REQ),
    .enable_i  (state_q == REQ),
    .expired_o (expired)
  );
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (start_i) begin
        state_d = amount_i == 3'd0 ? DONE : REQ;
        rem_d   = amount_i;
        err_d   = 1'b0;
      end
      // an ack in the timeout cycle still counts the coin
      REQ: if (hop_ack_i) begin
        state_d = REL;
        rem_d   = rem_q - (rem_q >= COIN_1 ? COIN_1 : COIN_05);
      end else if (expired) begin
        state_d = ERR;
        rem_d   = '0;
        err_d   = 1'b1;
      end
      REL: if (!hop_ack_i) state_d = rem_q == 3'd0 ? DONE : REQ;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      rem_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
    end
  end
  assign hop_1_o  = state_q == REQ && rem_q >= COIN_1;
  assign hop_05_o = state_q == REQ && rem_q == COIN_05;
  assign busy_o   = state_q == REQ || state_q == REL;
  assign done_o   = state_q == DONE;
  assign err_o    = err_q;
endmodule
